// File: rtl/carregador_pkg.sv
// Shared definitions for the instruction loader: state encoding and sizing constants.
package carregador_pkg;

  // Loader states; 3-bit encoding keeps the state register small.
  typedef enum logic [2:0] {
    LEN_HI    = 3'd0,
    LEN_LO    = 3'd1,
    RECEBE    = 3'd2,
    ESCREVE   = 3'd3,
    CHECKSUM  = 3'd4,
    CONCLUIDO = 3'd5,
    ERRO      = 3'd6
  } estado_t;

  localparam int BYTES_POR_PALAVRA = 4;
  localparam int MEM_WORDS_PADRAO  = 256;

endpackage

// File: rtl/carregador_instrucoes_montador.sv
// Big-endian word assembler: shifts bytes in MSB first and flags the 4th byte.
module montador_palavra
  import carregador_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        limpar_i,
  input  logic        deslocar_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] palavra_proxima_o,
  output logic        word_completa_o
);

  logic [31:0] palavra_q, palavra_d;
  logic [1:0]  contador_q, contador_d;

  // Word value including the byte being accepted now, so the writer can
  // register the complete word on the same edge as the last byte.
  assign palavra_proxima_o = {palavra_q[23:0], byte_i};
  assign word_completa_o   = deslocar_i && !limpar_i &&
                             (contador_q == 2'(BYTES_POR_PALAVRA - 1));

  // Next-state for the shift register and byte counter (clear has priority).
  always_comb begin
    palavra_d  = palavra_q;
    contador_d = contador_q;
    if (limpar_i) begin
      palavra_d  = '0;
      contador_d = '0;
    end else if (deslocar_i) begin
      palavra_d  = palavra_proxima_o;
      contador_d = contador_q + 2'd1;
    end
  end

  // Shift register and counter storage; the counter wraps after the 4th byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      palavra_q  <= '0;
      contador_q <= '0;
    end else begin
      palavra_q  <= palavra_d;
      contador_q <= contador_d;
    end
  end

endmodule

// File: rtl/carregador_instrucoes.sv
// Boot-time program loader: receives a framed byte stream, writes words into
// instruction memory from address 0, checks an XOR checksum and releases the
// processor reset only after a good load.
module carregador_instrucoes
  import carregador_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_PADRAO,
  parameter int LEN_W     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        recarregar,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);

  localparam logic [LEN_W-1:0] LIMITE = LEN_W'(MEM_WORDS);

  estado_t            estado_q, estado_d;
  logic [LEN_W-1:0]   comprimento_q, comprimento_d;
  logic [LEN_W-1:0]   indice_q, indice_d;
  logic [7:0]         xor_q, xor_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;

  logic               aceito;
  logic               limpar;
  logic               deslocar;
  logic               word_completa;
  logic [31:0]        palavra_proxima;
  logic [LEN_W-1:0]   comprimento_recebido;
  logic [LEN_W-1:0]   indice_mais_um;

  montador_palavra u_montador (
    .clk               (clk),
    .reset             (reset),
    .limpar_i          (limpar),
    .deslocar_i        (deslocar),
    .byte_i            (byte_data),
    .palavra_proxima_o (palavra_proxima),
    .word_completa_o   (word_completa)
  );

  // Ready only in byte-consuming states, and never while reset is held.
  assign byte_ready = reset && ((estado_q == LEN_HI) || (estado_q == LEN_LO) ||
                                (estado_q == RECEBE) || (estado_q == CHECKSUM));
  assign aceito               = byte_valid && byte_ready;
  assign comprimento_recebido = {comprimento_q[LEN_W-1:8], byte_data};
  assign indice_mais_um       = indice_q + 1'b1;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_reset = (estado_q != CONCLUIDO);
  assign done      = (estado_q == CONCLUIDO);
  assign error     = (estado_q == ERRO);

  // Next-state and datapath updates for the loader FSM.
  always_comb begin
    estado_d      = estado_q;
    comprimento_d = comprimento_q;
    indice_d      = indice_q;
    xor_d         = xor_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    limpar        = 1'b0;
    deslocar      = 1'b0;

    case (estado_q)
      LEN_HI: begin
        if (aceito) begin
          comprimento_d = {byte_data, comprimento_q[7:0]};
          xor_d         = xor_q ^ byte_data;
          estado_d      = LEN_LO;
        end
      end
      LEN_LO: begin
        if (aceito) begin
          comprimento_d = comprimento_recebido;
          xor_d         = xor_q ^ byte_data;
          indice_d      = '0;
          limpar        = 1'b1;
          if (comprimento_recebido == '0)
            estado_d = CHECKSUM;
          else if (comprimento_recebido > LIMITE)
            estado_d = ERRO;
          else
            estado_d = RECEBE;
        end
      end
      RECEBE: begin
        if (aceito) begin
          deslocar = 1'b1;
          xor_d    = xor_q ^ byte_data;
          if (word_completa) begin
            // Write port is registered: strobe and data are valid during ESCREVE.
            estado_d    = ESCREVE;
            mem_we_d    = 1'b1;
            mem_addr_d  = {{(30 - LEN_W){1'b0}}, indice_q, 2'b00};
            mem_wdata_d = palavra_proxima;
          end
        end
      end
      ESCREVE: begin
        indice_d = indice_mais_um;
        estado_d = (indice_mais_um == comprimento_q) ? CHECKSUM : RECEBE;
      end
      CHECKSUM: begin
        if (aceito)
          estado_d = (byte_data == xor_q) ? CONCLUIDO : ERRO;
      end
      CONCLUIDO, ERRO: begin
        if (recarregar) begin
          estado_d      = LEN_HI;
          comprimento_d = '0;
          indice_d      = '0;
          xor_d         = '0;
          limpar        = 1'b1;
        end
      end
      default: estado_d = LEN_HI;
    endcase
  end

  // State, counters, checksum and write-port registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q      <= LEN_HI;
      comprimento_q <= '0;
      indice_q      <= '0;
      xor_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      estado_q      <= estado_d;
      comprimento_q <= comprimento_d;
      indice_q      <= indice_d;
      xor_q         <= xor_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

endmodule

// File: doc/carregador_instrucoes.md
Name: carregador_instrucoes

Overview:
- Boot-time program loader and the writer side of the instruction-memory interface that Processador_MIPS reads from.
- Receives a framed byte stream, assembles big-endian 32-bit words, writes them sequentially from byte address 0, and verifies an XOR checksum.
- Holds the processor in reset until a load completes successfully, so programs load at runtime instead of only from the boot file.

Parameters:
- MEM_WORDS, 256, instruction-memory depth in words; maximum accepted program length.
- LEN_W, 16, width of the length header in bits; must be 16.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle.
- recarregar  in  1  single-cycle pulse; restarts loading from CONCLUIDO or ERRO.
- mem_we  out  1  instruction-memory write strobe, one cycle per word.
- mem_addr  out  32  byte address of the write; always word aligned.
- mem_wdata  out  32  assembled instruction word.
- cpu_reset  out  1  active-high reset driving Processador_MIPS.reset.
- done  out  1  load finished and checksum matched.
- error  out  1  length overflow or checksum mismatch.

Behaviour:
- Handshake: a byte transfers on a posedge with byte_valid=1 and byte_ready=1. byte_valid without byte_ready is ignored, and the source holds the byte.
- Frame format: LEN_HI, LEN_LO (word count N, big-endian), then 4·N payload bytes (MSB first per word), then one checksum byte. The checksum is the XOR of all preceding bytes, including both length bytes.
- States: LEN_HI -> LEN_LO -> RECEBE -> ESCREVE -> (RECEBE or CHECKSUM) -> CONCLUIDO or ERRO.
- byte_ready=1 only in LEN_HI, LEN_LO, RECEBE and CHECKSUM. It is 0 in ESCREVE, CONCLUIDO, ERRO and while reset=0.
- After LEN_LO is accepted:
  - N=0 -> CHECKSUM.
  - N>MEM_WORDS -> ERRO.
  - Otherwise -> RECEBE, with word index cleared.
- RECEBE: a 2-bit byte counter shifts bytes into the word register. When the 4th byte is accepted at edge k, the state is ESCREVE during cycle k+1.
- ESCREVE (exactly one cycle, registered outputs):
  - mem_we=1, mem_addr={word_index,2'b00}, mem_wdata=assembled word.
  - At the closing edge the word index increments.
  - If the new index equals N, go to CHECKSUM; otherwise go to RECEBE.
- CHECKSUM: the accepted byte is compared with the running XOR. Match -> CONCLUIDO; mismatch -> ERRO.
- CONCLUIDO: done=1, cpu_reset=0. ERRO: error=1, cpu_reset=1. Both states hold until recarregar or reset.
- recarregar is honoured only in CONCLUIDO and ERRO; it is ignored elsewhere. On the next edge:
  - state -> LEN_HI; cpu_reset -> 1; done and error -> 0.
  - Running XOR, byte counter and word index are cleared.
- cpu_reset is 1 in every state except CONCLUIDO.
- Reset (reset=0 at a posedge):
  - state=LEN_HI, mem_we=0, mem_addr=0, mem_wdata=0, cpu_reset=1, done=0, error=0.
  - Counters and XOR are cleared.
  - A reset in the middle of a frame discards the partial word. Words already written remain in memory.
- mem_addr wraps never: the index is bounded by N≤MEM_WORDS.
- mem_we is never asserted in any state other than ESCREVE.

Decomposition:
- Package carregador_pkg holds:
  - state encoding (LEN_HI, LEN_LO, RECEBE, ESCREVE, CHECKSUM, CONCLUIDO, ERRO; 3 bits);
  - BYTES_POR_PALAVRA=4;
  - default MEM_WORDS.
- Sub-module montador_palavra: a 4-byte shift register plus 2-bit counter with clear, shift-enable and word_completa outputs. The FSM, XOR accumulator and write port stay in carregador_instrucoes.

Test Plan:
- Load one word with bytes 00 01 8C 01 00 04, checksum 88 -> one mem_we pulse with mem_addr=0x0 and mem_wdata=0x8C010004. done=1, cpu_reset=0, error=0.
- Load two words 0x00221820 and 0x08000000 with the correct checksum -> writes at addresses 0x0 and 0x4 in order. byte_ready=0 during each ESCREVE cycle.
- Send the same one-word frame as the first test, but with checksum 0x89 -> error=1, done=0, cpu_reset stays 1. byte_ready=0 until recarregar.
- Send a length header of 0x0101 with MEM_WORDS=256 -> ERRO right after LEN_LO with no mem_we at all. Send a length of 0x0000 with checksum 00 -> CONCLUIDO with no writes.
- Toggle byte_valid randomly in the middle of a word, then assert reset=0 after 2 payload bytes -> no write of the partial word. A subsequent full frame loads correctly from address 0x0.
- Pulse recarregar in CONCLUIDO -> cpu_reset=1 and done=0 on the next cycle. A new frame overwrites from 0x0. A recarregar pulse during RECEBE has no effect.
